// File: rtl/electron_nest.sv
// electron_nest: boot-configured tile computing R[k] = max((A[k]+B[k])*C[k], 0)
// over operand vectors in external memory, with fixed-latency loads and stallable stores.
package pkg_en;
  localparam int WIDTH_DATA   = 32;
  localparam int WIDTH_EXADDR = 16;
  localparam int WIDTH_INDEX  = 8;

  typedef struct packed {
    logic                   v;
    logic                   a;
    logic                   r;
    logic                   c;
    logic [WIDTH_INDEX-1:0] i;
    logic [WIDTH_DATA-1:0]  d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

module electron_nest
  import pkg_en::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Boot,
  output logic                    O_Ld_Req,
  output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
  input  FTk_t                    I_Ld_FTk,
  output BTk_t                    O_Ld_BTk,
  output logic                    O_St_Req,
  output logic [WIDTH_EXADDR-1:0] O_St_Addr,
  output FTk_t                    O_St_FTk,
  input  BTk_t                    I_St_BTk
);

  typedef enum logic [3:0] {IDLE, BOOT, LDA, LDB, LDC, CAP, EXEC, ST, DONE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [WIDTH_EXADDR-1:0] a_base_q, a_base_d, b_base_q, b_base_d;
  logic [WIDTH_EXADDR-1:0] c_base_q, c_base_d, r_base_q, r_base_d;
  logic [15:0]             n_q, n_d, k_q, k_d;
  logic [WIDTH_DATA-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, r_q, r_d;
  logic [WIDTH_DATA-1:0]   sum_w, prod_w;
  logic                    last_k;
  logic                    unused_bits;

  assign unused_bits = ^{I_Ld_FTk.i, I_Ld_FTk.r, I_Ld_FTk.c, I_Ld_FTk.d[31:16],
                         I_St_BTk.t, I_St_BTk.v, I_St_BTk.c};

  assign last_k = (k_q == n_q - 16'd1);
  assign sum_w  = a_q + b_q;
  assign prod_w = sum_w * c_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      r_base_q <= '0;
      n_q      <= '0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      r_base_q <= r_base_d;
      n_q      <= n_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      r_q      <= r_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    r_base_d = r_base_q;
    n_d      = n_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    r_d      = r_q;
    case (state_q)
      IDLE: begin
        if (I_Boot && I_Ld_FTk.v && I_Ld_FTk.a) begin
          state_d = BOOT;
          cnt_d   = 3'd1;
        end
      end
      BOOT: begin
        // cnt_q counts frame words already consumed; words 0..2 are preamble
        if (I_Boot && I_Ld_FTk.v) begin
          cnt_d = cnt_q + 3'd1;
          case (cnt_q)
            3'd3: a_base_d = I_Ld_FTk.d[15:0];
            3'd4: b_base_d = I_Ld_FTk.d[15:0];
            3'd5: c_base_d = I_Ld_FTk.d[15:0];
            3'd6: r_base_d = I_Ld_FTk.d[15:0];
            3'd7: begin
              n_d     = I_Ld_FTk.d[15:0];
              k_d     = '0;
              state_d = (I_Ld_FTk.d[15:0] == 16'd0) ? DONE : LDA;
            end
            default: ;
          endcase
        end
      end
      LDA: state_d = LDB;
      LDB: begin
        a_d     = I_Ld_FTk.d;
        state_d = LDC;
      end
      LDC: begin
        b_d     = I_Ld_FTk.d;
        state_d = CAP;
      end
      CAP: begin
        c_d     = I_Ld_FTk.d;
        state_d = EXEC;
      end
      EXEC: begin
        r_d     = prod_w[31] ? '0 : prod_w;
        state_d = ST;
      end
      ST: begin
        if (!I_St_BTk.n) begin
          if (last_k) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 16'd1;
            state_d = LDA;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state, so reset clears them at once.
  always_comb begin
    O_Ld_Req  = 1'b0;
    O_Ld_Addr = '0;
    O_Ld_BTk  = '0;
    O_St_Req  = 1'b0;
    O_St_Addr = '0;
    O_St_FTk  = '0;
    case (state_q)
      LDA: begin
        O_Ld_Req  = 1'b1;
        O_Ld_Addr = a_base_q + k_q;
      end
      LDB: begin
        O_Ld_Req  = 1'b1;
        O_Ld_Addr = b_base_q + k_q;
      end
      LDC: begin
        O_Ld_Req   = 1'b1;
        O_Ld_Addr  = c_base_q + k_q;
        O_Ld_BTk.t = last_k;
      end
      ST: begin
        O_St_Req   = 1'b1;
        O_St_Addr  = r_base_q + k_q;
        O_St_FTk.v = 1'b1;
        O_St_FTk.a = (k_q == 16'd0);
        O_St_FTk.r = last_k;
        O_St_FTk.i = k_q[7:0];
        O_St_FTk.d = r_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_electron_nest.sv
// Directed bench for electron_nest: boot frames, ReLU kernel results, store stall,
// empty-vector boot and mid-run reset, against a small external memory model.
module tb_electron_nest;
  import pkg_en::*;

  logic        clock;
  logic        reset;
  logic        I_Boot;
  logic        O_Ld_Req;
  logic [15:0] O_Ld_Addr;
  FTk_t        I_Ld_FTk;
  BTk_t        O_Ld_BTk;
  logic        O_St_Req;
  logic [15:0] O_St_Addr;
  FTk_t        O_St_FTk;
  BTk_t        I_St_BTk;

  FTk_t        boot_tok;
  FTk_t        mem_tok;
  logic        boot_drv;
  logic [31:0] ld_mem [0:65535];

  typedef struct {
    logic [15:0] addr;
    logic [31:0] d;
    logic        a;
    logic        r;
  } st_rec_t;
  st_rec_t st_q[$];

  int tests = 0;
  int fails = 0;
  int ld_cnt = 0;
  int t_cnt = 0;
  int nack_cnt = 0;
  logic [15:0] t_addr = '0;

  electron_nest dut (
    .clock     (clock),
    .reset     (reset),
    .I_Boot    (I_Boot),
    .O_Ld_Req  (O_Ld_Req),
    .O_Ld_Addr (O_Ld_Addr),
    .I_Ld_FTk  (I_Ld_FTk),
    .O_Ld_BTk  (O_Ld_BTk),
    .O_St_Req  (O_St_Req),
    .O_St_Addr (O_St_Addr),
    .O_St_FTk  (O_St_FTk),
    .I_St_BTk  (I_St_BTk)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign I_Ld_FTk = boot_drv ? boot_tok : mem_tok;

  // External memory: fixed one-cycle load return, store capture and logging.
  always @(posedge clock) begin
    mem_tok <= '0;
    if (O_Ld_Req) begin
      mem_tok.v <= 1'b1;
      mem_tok.d <= ld_mem[O_Ld_Addr];
      ld_cnt    <= ld_cnt + 1;
    end
    if (O_Ld_BTk.t) begin
      t_cnt  <= t_cnt + 1;
      t_addr <= O_Ld_Addr;
    end
    if (O_Ld_BTk.n) nack_cnt <= nack_cnt + 1;
    if (O_St_Req && O_St_FTk.v && !I_St_BTk.n) begin
      st_q.push_back('{addr: O_St_Addr, d: O_St_FTk.d, a: O_St_FTk.a, r: O_St_FTk.r});
      $display("[TB] store addr=%04h data=%08h i=%0d a=%0d r=%0d",
               O_St_Addr, O_St_FTk.d, O_St_FTk.i, O_St_FTk.a, O_St_FTk.r);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int st_count(input logic [15:0] addr);
    int c = 0;
    foreach (st_q[j]) if (st_q[j].addr == addr) c++;
    return c;
  endfunction

  function automatic st_rec_t st_find(input logic [15:0] addr);
    st_rec_t rec = '{addr: 16'hxxxx, d: 32'hxxxxxxxx, a: 1'bx, r: 1'bx};
    foreach (st_q[j]) if (st_q[j].addr == addr) rec = st_q[j];
    return rec;
  endfunction

  // Sends 3 preamble words then 5 config words, with one v=0 gap inside.
  task automatic boot(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic [15:0] r, input logic [15:0] n);
    logic [31:0] w [8];
    w = '{32'd0, 32'd0, 32'd0, {16'd0, a}, {16'd0, b}, {16'd0, c}, {16'd0, r}, {16'hABCD, n}};
    boot_drv = 1'b1;
    I_Boot   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      boot_tok   = '0;
      boot_tok.v = 1'b1;
      boot_tok.a = (i == 0);
      boot_tok.d = w[i];
      @(negedge clock);
      if (i == 4) begin
        boot_tok   = '0;
        boot_tok.a = 1'b1;
        boot_tok.d = 32'hDEAD_BEEF;
        @(negedge clock);
      end
    end
    boot_tok = '0;
    boot_drv = 1'b0;
    I_Boot   = 1'b0;
  endtask

  task automatic wait_stores(input string tag, input int target, input int budget);
    int cyc = 0;
    while (st_q.size() < target && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    check(tag, st_q.size(), target);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ld_req"}, O_Ld_Req, 0);
    check({tag, "_ld_addr"}, O_Ld_Addr, 0);
    check({tag, "_ld_btk"}, O_Ld_BTk, 0);
    check({tag, "_st_req"}, O_St_Req, 0);
    check({tag, "_st_addr"}, O_St_Addr, 0);
    check({tag, "_st_ftk"}, O_St_FTk, 0);
  endtask

  initial begin
    int lat;
    int ld0;
    int st0;
    int cyc;
    st_rec_t rec;
    logic [31:0] exp1 [4];

    reset    = 1'b0;
    I_Boot   = 1'b0;
    boot_drv = 1'b0;
    boot_tok = '0;
    I_St_BTk = '0;

    // Run 1 data
    ld_mem[16'h0010] = 32'd3; ld_mem[16'h0011] = 32'd1; ld_mem[16'h0012] = 32'd0; ld_mem[16'h0013] = 32'd2;
    ld_mem[16'h0020] = 32'd4; ld_mem[16'h0021] = 32'd1; ld_mem[16'h0022] = 32'd0; ld_mem[16'h0023] = 32'd2;
    ld_mem[16'h0030] = 32'd5; ld_mem[16'h0031] = 32'd7; ld_mem[16'h0032] = 32'd9; ld_mem[16'h0033] = 32'hFFFFFFFF;
    // Run 2: sign / overflow cases, k=1 is the stalled non-zero result
    ld_mem[16'h0100] = 32'hFFFFFFF6; ld_mem[16'h0101] = 32'h40000000; ld_mem[16'h0102] = 32'h7FFFFFFF;
    ld_mem[16'h0110] = 32'd2;        ld_mem[16'h0111] = 32'd0;        ld_mem[16'h0112] = 32'd1;
    ld_mem[16'h0120] = 32'd1;        ld_mem[16'h0121] = 32'd1;        ld_mem[16'h0122] = 32'd2;
    // Run 3 (N=1) and run 4 (reset abort)
    ld_mem[16'h0200] = 32'd6; ld_mem[16'h0210] = 32'd4; ld_mem[16'h0220] = 32'd3;
    for (int j = 0; j < 4; j++) begin
      ld_mem[16'h0300 + 16'(j)] = 32'(j + 1);
      ld_mem[16'h0310 + 16'(j)] = 32'd1;
      ld_mem[16'h0320 + 16'(j)] = 32'd1;
    end

    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    check("reset_state", 64'(dut.state_q), 0);
    reset = 1'b1;
    @(negedge clock);

    // ---- Run 1: basic kernel, N=4 ----
    boot(16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'd4);
    lat = 0;
    while (!O_Ld_Req && lat < 3) begin
      @(negedge clock);
      lat++;
    end
    check("first_ld_within_2", (lat <= 2), 1);
    check("first_ld_addr", O_Ld_Addr, 16'h0010);
    wait_stores("run1_store_count", 4, 200);
    exp1 = '{32'd35, 32'd14, 32'd0, 32'd0};
    for (int j = 0; j < 4; j++) begin
      rec = st_find(16'h0040 + 16'(j));
      check($sformatf("run1_r%0d", j), rec.d, exp1[j]);
      check($sformatf("run1_a%0d", j), rec.a, (j == 0));
      check($sformatf("run1_last%0d", j), rec.r, (j == 3));
    end
    check("run1_t_pulses", t_cnt, 1);
    check("run1_t_addr", t_addr, 16'h0033);
    check("run1_ld_count", ld_cnt, 12);
    repeat (3) @(negedge clock);
    check("run1_idle", 64'(dut.state_q), 0);

    // ---- Run 2: sign/overflow + store stall on k=1 ----
    boot(16'h0100, 16'h0110, 16'h0120, 16'h0130, 16'd3);
    cyc = 0;
    while (!(O_St_Req && O_St_Addr == 16'h0131) && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("run2_reach_st_k1", (O_St_Req && O_St_Addr == 16'h0131), 1);
    I_St_BTk.n = 1'b1;
    ld0 = ld_cnt;
    st0 = st_q.size();
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      check($sformatf("stall%0d_req", s), O_St_Req, 1);
      check($sformatf("stall%0d_addr", s), O_St_Addr, 16'h0131);
      check($sformatf("stall%0d_data", s), O_St_FTk.d, 32'h40000000);
      check($sformatf("stall%0d_noload", s), O_Ld_Req, 0);
    end
    check("stall_no_loads", ld_cnt, ld0);
    check("stall_no_store", st_q.size(), st0);
    I_St_BTk.n = 1'b0;
    wait_stores("run2_store_count", 7, 200);
    check("run2_r0", st_find(16'h0130).d, 32'd0);
    check("run2_r1", st_find(16'h0131).d, 32'h40000000);
    check("run2_r2", st_find(16'h0132).d, 32'd0);
    for (int j = 0; j < 3; j++)
      check($sformatf("run2_writes%0d", j), st_count(16'h0130 + 16'(j)), 1);
    check("run2_t_pulses", t_cnt, 2);

    // ---- Run 3: N=0 then N=1 ----
    repeat (3) @(negedge clock);
    ld0 = ld_cnt;
    st0 = st_q.size();
    boot(16'h0200, 16'h0210, 16'h0220, 16'h0230, 16'd0);
    repeat (20) @(negedge clock);
    check("n0_no_loads", ld_cnt, ld0);
    check("n0_no_stores", st_q.size(), st0);
    check("n0_idle", 64'(dut.state_q), 0);
    boot(16'h0200, 16'h0210, 16'h0220, 16'h0230, 16'd1);
    wait_stores("n1_store_count", st0 + 1, 100);
    rec = st_find(16'h0230);
    check("n1_result", rec.d, 32'd30);
    check("n1_a", rec.a, 1);
    check("n1_r", rec.r, 1);

    // ---- Run 4: reset during LDB of k=2 ----
    repeat (3) @(negedge clock);
    st0 = st_q.size();
    boot(16'h0300, 16'h0310, 16'h0320, 16'h0330, 16'd4);
    cyc = 0;
    while (!(O_Ld_Req && O_Ld_Addr == 16'h0312) && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("rst_reach_ldb_k2", (O_Ld_Req && O_Ld_Addr == 16'h0312), 1);
    check("rst_prior_stores", st_q.size(), st0 + 2);
    reset = 1'b0;
    #1;
    check_outputs_zero("midrst");
    check("midrst_state", 64'(dut.state_q), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    check("rst_no_more_stores", st_q.size(), st0 + 2);
    check("rst_no_k2_store", st_count(16'h0332), 0);
    check("rst_idle", 64'(dut.state_q), 0);
    check("never_nack", nack_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/electron_nest.md
# electron_nest

Top-level compute tile for the vector add–multiply–compare (ReLU) kernel. It is configured by a five-word boot frame on the load port, streams three operand vectors from external memory, and computes R[k] = max((A[k]+B[k])·C[k], 0). Each result is written back through the store port. It sits between the external memory model and nothing else; all traffic uses the pkg_en forward/backward token types.

## Interface
- WIDTH_DATA, 32, data word width (pkg_en)
- WIDTH_EXADDR, 16, external word-address width (pkg_en)
- WIDTH_INDEX, 8, token index width (pkg_en)
- FTk_t fields: v valid, a acquire (first), r release (last), c condition, i[WIDTH_INDEX], d[WIDTH_DATA]. BTk_t fields: n nack, t terminate, v, c.
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- I_Boot  in  1  boot window; config frame arrives on I_Ld_FTk
- O_Ld_Req  out  1  load request
- O_Ld_Addr  out  WIDTH_EXADDR  load word address
- I_Ld_FTk  in  FTk_t  load return / boot words
- O_Ld_BTk  out  BTk_t  load backward token
- O_St_Req  out  1  store request
- O_St_Addr  out  WIDTH_EXADDR  store word address
- O_St_FTk  out  FTk_t  store data token
- I_St_BTk  in  BTk_t  store backward token (n = stall)

## Operation
- FSM states: IDLE, BOOT, LDA, LDB, LDC, CAP, EXEC, ST, DONE.
- IDLE: on a valid I_Ld_FTk word with a=1, enter BOOT. That word is preamble word 0.
- BOOT: the first 3 valid words (including the a=1 word) are routing preamble and are discarded. The next 5 valid words load CFG0..CFG4: A base, B base, C base, R base, and N (length, CFG4[15:0]). Words with v=0 are ignored. After the 5th config word, k=0; go to LDA, or to DONE if N=0.
- LDA/LDB/LDC: one cycle each, O_Ld_Req=1 with address A+k, B+k and C+k respectively. LDB captures the A data; LDC captures the B data.
- CAP: captures the C data.
- EXEC: computes P = ((A+B) mod 2^32 · C) mod 2^32 and registers R = P if P is signed-positive, else 0.
- ST: O_St_Req=1, O_St_Addr = Rbase+k, O_St_FTk.v=1, d=R, i=k[7:0], a=(k==0), r=(k==N-1), c=0. Hold ST while I_St_BTk.n=1. On a cycle with n=0, increment k; go to LDA, or to DONE if k==N-1.
- DONE: one cycle, then IDLE. A new boot frame reruns the kernel with new config.
- O_Ld_BTk: n=0 always (the DUT absorbs every return). t=1 during the LDC cycle of the last element. v=c=0.
- I_Ld_FTk.i, .r, .c are ignored. I_Boot only qualifies the frame; a-marked words are ignored when not in IDLE.
- Addresses wrap modulo 2^WIDTH_EXADDR.

## Timing
- All outputs are registered/decoded from state. Reset value of every output and config register is 0; the FSM resets to IDLE.
- Load latency is fixed: a request sampled at edge t returns data with v=1 during the following cycle. It is captured at edge t+1. No load stall exists.
- A store completes at the edge where O_St_Req & O_St_FTk.v & ~I_St_BTk.n.
- With no store stall, each element takes 6 cycles (LDA..ST).
- Store outputs are held stable while stalled.
- Reset asserted mid-operation aborts immediately; no partial store is issued after reset.

## Test plan
- Boot: 3 zero preamble words (first with a=1), then config 0x0010, 0x0020, 0x0030, 0x0040, 4 -> first O_Ld_Req with addr 0x0010 within 2 cycles after the last config word.
- Data A={3,1,0,2}, B={4,1,0,2}, C={5,7,9,0xFFFFFFFF} -> mem[0x40..0x43] = {35, 14, 0, 0}. Store a=1 on k=0, r=1 on k=3. O_Ld_BTk.t pulses exactly once, with the load to 0x0033.
- Sign/overflow: A=0xFFFFFFF6, B=2, C=1 -> 0. A=0x7FFFFFFF, B=1, C=2 -> 0. A=0x40000000, B=0, C=1 -> 0x40000000.
- Store stall: hold I_St_BTk.n=1 for 5 cycles during ST of k=1 -> addr/data held, no new load requests, exactly one write per element.
- N=0 boot -> no load or store requests; FSM returns to IDLE. A second boot with N=1 then runs normally.
- Reset asserted during LDB of k=2 -> all outputs 0 on the next cycle, FSM in IDLE, no further stores.
